// File: rtl/ssg_scan_driver.sv
// Three-digit multiplexed seven-segment driver with a double-buffered digit
// load, frame-aligned commit and whole-display blink.
module ssg_scan_driver #(
    parameter int SCAN_COUNT  = 100000,
    parameter int BLINK_COUNT = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic       blink,
    output logic       pending,
    output logic [6:0] SSG_D,
    output logic [2:0] SSG_EN
);

    localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int BW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_COUNT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_COUNT - 1);

    logic [SW-1:0]     scan_cnt;
    logic [1:0]        idx;
    logic [2:0][3:0]   shadow;
    logic [2:0][3:0]   disp;
    logic [BW-1:0]     blink_cnt;
    logic              phase_on;

    logic              scan_wrap;
    logic              frame_end;
    logic [3:0]        cur_code;
    logic [2:0]        en_pat;
    logic [6:0]        seg_pat;

    function automatic logic [6:0] encode(input logic [3:0] code);
        case (code)
            4'h0:    encode = 7'b1000000;
            4'h1:    encode = 7'b1111001;
            4'h2:    encode = 7'b0100100;
            4'h3:    encode = 7'b0110000;
            4'h4:    encode = 7'b0011001;
            4'h5:    encode = 7'b0010010;
            4'h6:    encode = 7'b0000010;
            4'h7:    encode = 7'b1111000;
            4'h8:    encode = 7'b0000000;
            4'h9:    encode = 7'b0010000;
            4'hE:    encode = 7'b0000110;
            default: encode = 7'b1111111;
        endcase
    endfunction

    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign frame_end = scan_wrap && (idx == 2'd2);

    always_comb begin
        cur_code = 4'hF;
        en_pat   = 3'b111;
        case (idx)
            2'd0: begin cur_code = disp[0]; en_pat = 3'b110; end
            2'd1: begin cur_code = disp[1]; en_pat = 3'b101; end
            2'd2: begin cur_code = disp[2]; en_pat = 3'b011; end
            default: begin cur_code = 4'hF; en_pat = 3'b111; end
        endcase
        seg_pat = encode(cur_code);
    end

    // Outputs are registered from the state before the edge, so the enable
    // and its digit data always change together and commits never tear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt  <= '0;
            idx       <= 2'd0;
            shadow    <= '1;
            disp      <= '1;
            pending   <= 1'b0;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            SSG_EN    <= 3'b111;
            SSG_D     <= 7'b1111111;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            // A load on the boundary edge wins pending back after the commit.
            if (frame_end && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            if (load) begin
                shadow  <= {digit2, digit1, digit0};
                pending <= 1'b1;
            end

            if (!blink) begin
                blink_cnt <= '0;
                phase_on  <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase_on  <= ~phase_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            if (blink && !phase_on) begin
                SSG_EN <= 3'b111;
                SSG_D  <= 7'b1111111;
            end else begin
                SSG_EN <= en_pat;
                SSG_D  <= seg_pat;
            end
        end
    end

endmodule

// File: tb/tb_ssg_scan_driver.sv
// Directed bench for ssg_scan_driver with SCAN_COUNT=4, BLINK_COUNT=10;
// expected outputs come from hand-derived cycle numbers and segment constants.
module tb_ssg_scan_driver;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic       blink;
    logic       pending;
    logic [6:0] SSG_D;
    logic [2:0] SSG_EN;

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [6:0] seg_exp [3];
    logic       exp_blank;
    logic       exp_pending;

    localparam logic [6:0] BLANK = 7'b1111111;

    ssg_scan_driver #(.SCAN_COUNT(4), .BLINK_COUNT(10)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .digit0(digit0),
        .digit1(digit1),
        .digit2(digit2),
        .blink(blink),
        .pending(pending),
        .SSG_D(SSG_D),
        .SSG_EN(SSG_EN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b expected %b", tag, n, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Each enable is held 4 cycles after release: outputs 1..4 -> 110, 5..8 -> 101, 9..12 -> 011.
    task automatic run_to(input int target);
        int k;
        logic [2:0] en;
        logic [6:0] d;
        while (n < target) begin
            cycle();
            k  = ((n - 1) / 4) % 3;
            en = (k == 0) ? 3'b110 : (k == 1) ? 3'b101 : 3'b011;
            d  = seg_exp[k];
            if (exp_blank) begin
                en = 3'b111;
                d  = BLANK;
            end
            checkOutput("SSG_EN", {5'b0, SSG_EN}, {5'b0, en});
            checkOutput("SSG_D", {1'b0, SSG_D}, {1'b0, d});
            checkOutput("pending", {7'b0, pending}, {7'b0, exp_pending});
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        load   = 1'b1;
        digit0 = d0;
        digit1 = d1;
        digit2 = d2;
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; blink = 1'b0;
        digit0 = 4'h0; digit1 = 4'h0; digit2 = 4'h0;
        seg_exp = '{BLANK, BLANK, BLANK};
        exp_blank = 1'b0;
        exp_pending = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_EN", {5'b0, SSG_EN}, 8'b0000_0111);
            checkOutput("reset_D", {1'b0, SSG_D}, {1'b0, BLANK});
            checkOutput("reset_pending", {7'b0, pending}, 8'd0);
        end
        reset = 1'b1;
        n = 0;
        $display("[TB] idle scan");
        run_to(24);

        $display("[TB] mid-frame load 1,2,3");
        run_to(28);
        applyStimulus(4'd1, 4'd2, 4'd3);
        exp_pending = 1'b1;
        run_to(29);
        load = 1'b0;
        run_to(35);
        exp_pending = 1'b0;
        run_to(36);
        seg_exp = '{7'b1111001, 7'b0100100, 7'b0110000};
        run_to(48);

        $display("[TB] code map E,A,8");
        run_to(49);
        applyStimulus(4'hE, 4'hA, 4'h8);
        exp_pending = 1'b1;
        run_to(50);
        load = 1'b0;
        run_to(59);
        exp_pending = 1'b0;
        run_to(60);
        seg_exp = '{7'b0000110, BLANK, 7'b0000000};
        run_to(72);

        $display("[TB] overwrite");
        run_to(73);
        applyStimulus(4'd4, 4'd5, 4'd6);
        exp_pending = 1'b1;
        run_to(74);
        load = 1'b0;
        run_to(77);
        applyStimulus(4'd7, 4'd8, 4'd9);
        run_to(78);
        load = 1'b0;
        run_to(83);
        exp_pending = 1'b0;
        run_to(84);
        seg_exp = '{7'b1111000, 7'b0000000, 7'b0010000};
        run_to(96 - 7);

        $display("[TB] coincident load");
        applyStimulus(4'd3, 4'd4, 4'd5);
        exp_pending = 1'b1;
        run_to(90);
        load = 1'b0;
        run_to(95);
        applyStimulus(4'd0, 4'd9, 4'hE);
        run_to(96);
        load = 1'b0;
        seg_exp = '{7'b0110000, 7'b0011001, 7'b0010010};
        run_to(107);
        exp_pending = 1'b0;
        run_to(108);
        seg_exp = '{7'b1000000, 7'b0010000, 7'b0000110};
        run_to(120);

        $display("[TB] blink");
        blink = 1'b1;
        run_to(130);
        exp_blank = 1'b1;
        run_to(140);
        exp_blank = 1'b0;
        run_to(150);
        exp_blank = 1'b1;
        run_to(155);
        blink = 1'b0;
        exp_blank = 1'b0;
        run_to(162);

        $display("[TB] reset mid-operation");
        run_to(163);
        blink = 1'b1;
        run_to(165);
        applyStimulus(4'd1, 4'd1, 4'd1);
        exp_pending = 1'b1;
        run_to(166);
        load = 1'b0;
        run_to(167);
        reset = 1'b0;
        cycle();
        checkOutput("midreset_EN", {5'b0, SSG_EN}, 8'b0000_0111);
        checkOutput("midreset_D", {1'b0, SSG_D}, {1'b0, BLANK});
        checkOutput("midreset_pending", {7'b0, pending}, 8'd0);
        cycle();
        reset = 1'b1;
        blink = 1'b0;
        n = 0;
        exp_pending = 1'b0;
        seg_exp = '{BLANK, BLANK, BLANK};
        run_to(24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
